// File: rtl/user_uart_tx.sv
// -----------------------------------------------------------------------------
// user_uart_tx
//   8N1 UART transmitter for the user project area. A small FIFO buffers the
//   bytes that arrive on a valid/ready write port. A four-state FSM
//   (IDLE/START/DATA/STOP) serialises each byte LSB first. Each bit lasts a
//   programmable number of clocks, and that period is latched when a frame
//   starts.
//
// Parameters
//   FIFO_AW     FIFO address width; depth = 2**FIFO_AW
//   DIV_W       width of baud_div
//
// Ports
//   wb_clk_i    in   system clock, rising edge
//   wb_rst_i    in   asynchronous reset, active-high
//   tx_en       in   1 = new frames may start; 0 = stay IDLE after current frame
//   baud_div    in   bit period in clocks (0 and 1 behave as 2)
//   wr_data     in   byte to queue
//   wr_valid    in   write request
//   wr_ready    out  FIFO not full (from registered level)
//   ser_tx      out  registered serial line, idle high
//   busy        out  FSM active or FIFO non-empty
//   fifo_level  out  number of queued bytes (0..2**FIFO_AW)
//   frame_done  out  one-cycle pulse on the final cycle of each stop bit
// -----------------------------------------------------------------------------
module user_uart_tx #(
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               tx_en,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic [7:0]         wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic               ser_tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               frame_done
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // A divider below 2 cannot form a usable bit, so it is raised to 2.
    function automatic logic [DIV_W-1:0] clamp_period(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(2)) ? DIV_W'(2) : div;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               push;
    logic               pop;

    // wr_ready comes only from the registered level. A same-cycle pop
    // therefore never opens a slot for a push while the FIFO is full.
    assign wr_ready   = (level_q != FULL_LVL);
    assign push       = wr_valid && wr_ready;
    assign fifo_level = level_q;

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------------------------------------------------- serialiser
    state_t           state_q, state_d;
    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [7:0]       shift_q, shift_d;
    logic             ser_q, ser_d;
    logic             bit_end;

    assign bit_end = (bit_cnt_q == period_q - DIV_W'(1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        period_d  = period_q;
        shift_d   = shift_q;
        ser_d     = ser_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                if (tx_en && (level_q != '0)) begin
                    pop       = 1'b1;
                    shift_d   = mem[rd_ptr_q];
                    period_d  = clamp_period(baud_div);
                    bit_cnt_d = '0;
                    state_d   = S_START;
                    ser_d     = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = S_DATA;
                    ser_d     = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        ser_d   = 1'b1;
                    end else begin
                        // The line register is loaded with the next bit, taken
                        // before the shift, so it changes on the same edge
                        // that ends the current bit.
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        ser_d   = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= 3'd0;
            ser_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            ser_q     <= ser_d;
        end
    end

    // Frame payload and latched period: only read once a frame has started.
    always_ff @(posedge wb_clk_i) begin
        shift_q  <= shift_d;
        period_q <= period_d;
    end

    assign ser_tx     = ser_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign frame_done = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_user_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_user_uart_tx
//   Directed bench for user_uart_tx. It drives inputs on the falling edge and
//   samples outputs on the falling edge. Serial frames are checked one cycle
//   at a time against the bit pattern expected for the byte and the period.
// -----------------------------------------------------------------------------
module tb_user_uart_tx;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        tx_en    = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [7:0]  wr_data  = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        ser_tx;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    user_uart_tx #(.FIFO_AW(3), .DIV_W(16)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frame_done (frame_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Called on a falling edge; the byte is offered on exactly one rising edge.
    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        @(negedge wb_clk_i);
        wr_valid = 1'b0;
    endtask

    // Number of falling edges until ser_tx is low (bounded).
    task automatic wait_fall(output int n);
        n = 0;
        while (ser_tx !== 1'b0 && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
    endtask

    // Checks frame cycles first_k..10*p. The sample already present is cycle
    // first_k. Cycle 1 is the first cycle of the start bit.
    task automatic rx_frame(input int p, input logic [7:0] b, input string tag, input int first_k);
        int         bad;
        int         bi;
        logic       expv;
        logic [7:0] got;
        bad = 0;
        got = 8'h00;
        for (int k = first_k; k <= 10 * p; k++) begin
            if (k > first_k) @(negedge wb_clk_i);
            bi = (k - 1) / p;
            if (bi == 0)      expv = 1'b0;
            else if (bi == 9) expv = 1'b1;
            else              expv = b[bi-1];
            if (ser_tx !== expv) bad++;
            if (frame_done !== (k == 10 * p)) bad++;
            if (bi >= 1 && bi <= 8 && ((k - 1) % p) == p / 2) got[bi-1] = ser_tx;
        end
        chk({tag, "_byte"}, got, b);
        chk({tag, "_shape"}, bad, 0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        int lows;
        logic r;

        // Reset values
        repeat (2) @(negedge wb_clk_i);
        chk("rst_ser_tx", ser_tx, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_frame_done", frame_done, 0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // T1: 0xA5 at period 4
        tx_en    = 1'b1;
        baud_div = 16'd4;
        push(8'hA5);
        chk("t1_prefall", ser_tx, 1);
        chk("t1_level", fifo_level, 1);
        wait_fall(n);
        chk("t1_latency", n, 1);
        rx_frame(4, 8'hA5, "t1", 1);
        @(negedge wb_clk_i);
        chk("t1_idle_line", ser_tx, 1);
        chk("t1_idle_busy", busy, 0);

        // T2/T6: fill FIFO with tx_en=0, then a full-FIFO push races a pop
        tx_en    = 1'b0;
        wr_valid = 1'b1;
        acc      = 0;
        for (int c = 0; c < 20; c++) begin
            wr_data = acc[7:0];
            r       = wr_ready;
            @(negedge wb_clk_i);
            if (r) acc++;
        end
        chk("t2_accepted", acc, 8);
        chk("t2_level_full", fifo_level, 8);
        chk("t2_ready_full", wr_ready, 0);
        chk("t2_line_held", ser_tx, 1);
        chk("t2_busy", busy, 1);
        tx_en = 1'b1;
        @(negedge wb_clk_i);
        chk("t6_start", ser_tx, 0);
        chk("t6_push_refused", fifo_level, 7);
        chk("t6_ready_back", wr_ready, 1);
        @(negedge wb_clk_i);
        chk("t6_push_next", fifo_level, 8);
        wr_valid = 1'b0;
        rx_frame(4, 8'h00, "t2_f0", 2);
        for (int i = 1; i <= 8; i++) begin
            wait_fall(n);
            chk($sformatf("t2_gap%0d", i), n, 2);
            rx_frame(4, i[7:0], $sformatf("t2_f%0d", i), 1);
        end
        @(negedge wb_clk_i);
        chk("t2_done_busy", busy, 0);
        chk("t2_done_level", fifo_level, 0);

        // T3: divider 0 and 1 both give a 2-cycle bit
        baud_div = 16'd0;
        push(8'hFF);
        wait_fall(n);
        chk("t3a_latency", n, 1);
        rx_frame(2, 8'hFF, "t3a", 1);
        @(negedge wb_clk_i);
        baud_div = 16'd1;
        push(8'hFF);
        wait_fall(n);
        chk("t3b_latency", n, 1);
        rx_frame(2, 8'hFF, "t3b", 1);

        // T4: divider change after the frame has latched its period
        @(negedge wb_clk_i);
        tx_en    = 1'b0;
        baud_div = 16'd4;
        push(8'h3C);
        push(8'hC3);
        tx_en = 1'b1;
        wait_fall(n);
        chk("t4_latency", n, 1);
        baud_div = 16'd8;
        rx_frame(4, 8'h3C, "t4a", 1);
        wait_fall(n);
        chk("t4_gap", n, 2);
        rx_frame(8, 8'hC3, "t4b", 1);

        // T5: reset during data bit 3 with three bytes queued
        @(negedge wb_clk_i);
        tx_en    = 1'b0;
        baud_div = 16'd4;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        tx_en = 1'b1;
        wait_fall(n);
        chk("t5_latency", n, 1);
        repeat (17) @(negedge wb_clk_i);
        chk("t5_level_pre", fifo_level, 3);
        #1;
        wb_rst_i = 1'b1;
        #1;
        chk("t5_rst_line", ser_tx, 1);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", wr_ready, 1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        lows     = 0;
        repeat (20) begin
            @(negedge wb_clk_i);
            if (ser_tx !== 1'b1) lows++;
        end
        chk("t5_quiet_line", lows, 0);
        chk("t5_quiet_busy", busy, 0);
        push(8'h81);
        wait_fall(n);
        chk("t5_new_latency", n, 1);
        rx_frame(4, 8'h81, "t5", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
